// File: rtl/mips_seg7scan.sv
// mips_seg7scan
// Memory-mapped, time-multiplexed seven-segment display controller on the
// MIPS data bus. One digit at a time is driven; each digit owns a slot of
// SCAN_DIV clocks, the first BLANK_CYC of which keep every digit enable off
// so the previous digit's segments cannot ghost onto the next one.
//
// Registers:
//   BASE_ADDR   DATA  nibble i = hex value of digit i (unused upper bits read 0)
//   BASE_ADDR+4 CTRL  [0] EN, [1] LZB, [15:8] DP mask, [23:16] BLANK mask
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   addr_i      data-bus byte address
//   din         data-bus write data
//   dmem_ctl_i  store control (DMEM_SW full word, DMEM_SB low byte)
//   dout        combinational readback, 0 when not addressed
//   seg_o       {dp,g,f,e,d,c,b,a} of the scanned digit
//   dig_en_o    one-hot digit enable, bit 0 = least significant digit
module mips_seg7scan #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010,
    parameter int          NDIGITS    = 4,
    parameter int          SCAN_DIV   = 50000,
    parameter int          BLANK_CYC  = 16,
    parameter bit          SEG_ACT_LO = 1'b0,
    parameter logic [3:0]  DMEM_SB    = 4'd1,
    parameter logic [3:0]  DMEM_SW    = 4'd3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        din,
    input  logic [3:0]         dmem_ctl_i,
    output logic [31:0]        dout,
    output logic [7:0]         seg_o,
    output logic [NDIGITS-1:0] dig_en_o
);

    localparam int DW = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [31:0]   CTRL_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

    // register file
    logic [DW-1:0]      data_q, data_d;
    logic               en_q, en_d;
    logic               lzb_q, lzb_d;
    logic [7:0]         dp_q, dp_d;
    logic [7:0]         blank_q, blank_d;
    // scan state
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    // registered outputs, logical polarity
    logic [7:0]         seg_q, seg_d;
    logic [NDIGITS-1:0] dig_q, dig_d;

    logic        sel_data, sel_ctrl, wr_any, wr_word;
    logic [31:0] data_w;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        case (v)
            4'h0: seg7_decode = 7'b0111111;
            4'h1: seg7_decode = 7'b0000110;
            4'h2: seg7_decode = 7'b1011011;
            4'h3: seg7_decode = 7'b1001111;
            4'h4: seg7_decode = 7'b1100110;
            4'h5: seg7_decode = 7'b1101101;
            4'h6: seg7_decode = 7'b1111101;
            4'h7: seg7_decode = 7'b0000111;
            4'h8: seg7_decode = 7'b1111111;
            4'h9: seg7_decode = 7'b1101111;
            4'hA: seg7_decode = 7'b1110111;
            4'hB: seg7_decode = 7'b1111100;
            4'hC: seg7_decode = 7'b0111001;
            4'hD: seg7_decode = 7'b1011110;
            4'hE: seg7_decode = 7'b1111001;
            4'hF: seg7_decode = 7'b1110001;
        endcase
    endfunction

    assign sel_data = (addr_i == BASE_ADDR);
    assign sel_ctrl = (addr_i == CTRL_ADDR);
    assign wr_word  = (dmem_ctl_i == DMEM_SW);
    assign wr_any   = wr_word || (dmem_ctl_i == DMEM_SB);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            en_q    <= 1'b0;
            lzb_q   <= 1'b0;
            dp_q    <= '0;
            blank_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
        end else begin
            data_q  <= data_d;
            en_q    <= en_d;
            lzb_q   <= lzb_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    // ---------------- register writes ----------------
    always_comb begin
        // widen to a full word so a byte store also works when DW < 8
        data_w  = 32'(data_q);
        en_d    = en_q;
        lzb_d   = lzb_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (wr_any && sel_data) begin
            if (wr_word) data_w = din;
            else         data_w[7:0] = din[7:0];
        end
        if (wr_any && sel_ctrl) begin
            en_d  = din[0];
            lzb_d = din[1];
            if (wr_word) begin
                dp_d    = din[15:8];
                blank_d = din[23:16];
            end
        end
        data_d = data_w[DW-1:0];
    end

    // ---------------- scan next state ----------------
    always_comb begin
        cnt_d = '0;
        idx_d = '0;
        if (en_q) begin
            if (cnt_q == CNT_LAST) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    // ---------------- output decode ----------------
    logic [NDIGITS-1:0] lz_dark;
    logic               all_zero;
    logic [3:0]         nib;
    logic               dark;

    // lz_dark[i]: digit i and every digit above it hold zero (digit 0 exempt)
    always_comb begin
        all_zero = 1'b1;
        lz_dark  = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (data_q[4*i +: 4] == 4'h0);
            lz_dark[i] = all_zero && (i != 0);
        end
    end

    always_comb begin
        nib   = data_q[{idx_q, 2'b00} +: 4];
        dark  = blank_q[idx_q] || (lzb_q && lz_dark[idx_q]);
        seg_d = '0;
        dig_d = '0;
        if (en_q && (cnt_q >= CNT_BLANK)) begin
            dig_d = NDIGITS'(1) << idx_q;
            seg_d = {dp_q[idx_q], dark ? 7'h00 : seg7_decode(nib)};
        end
    end

    // ---------------- bus readback and pins ----------------
    always_comb begin
        dout = 32'h0;
        if (sel_data)      dout = 32'(data_q);
        else if (sel_ctrl) dout = {8'h00, blank_q, dp_q, 6'h00, lzb_q, en_q};
    end

    assign seg_o    = seg_q ^ {8{SEG_ACT_LO}};
    assign dig_en_o = dig_q ^ {NDIGITS{SEG_ACT_LO}};

endmodule
